riscv_dmem_ctrl: RTL and testbench
==================================

Name: riscv_dmem_ctrl

Overview:
- Parametrised, byte-addressable data memory for the RISC-V core. It is the successor to the word-only data memory.
- Supports RV32I load/store widths (byte, half, word) with byte-lane write enables and sign/zero extension.
- Uses a registered, handshaked 1-cycle access and flags misaligned or out-of-range accesses.
- After reset, a clear state machine zeroes the array one word per cycle instead of in a zero-time loop. Sits between the execute stage and writeback.

Parameters:
- ADDR_WIDTH, 16, word-index bits; depth = 2**ADDR_WIDTH words of 32 bits.
- CLEAR_ON_RESET, 1, 1 = sweep the array to zero after reset; 0 = go straight to IDLE with contents unchanged.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- Req  input  1  access request.
- Write  input  1  1 = store, 0 = load; sampled with Req.
- Funct3  input  3  RV32I width code; sampled with Req.
- Address  input  32  byte address.
- WD  input  32  store data, right-justified.
- Ready  output  1  block can accept a request this cycle.
- Ack  output  1  one-cycle pulse, the cycle after an accepted request.
- RD  output  32  load result, valid while Ack=1 and the access was a load.
- Fault  output  1  valid with Ack; 1 = access rejected.
- Busy  output  1  clear sweep in progress.

Behaviour:
- Reset (RST=0, asynchronous):
  - state <= CLEAR (or IDLE if CLEAR_ON_RESET=0); clr_ptr <= 0.
  - Ready=0, Ack=0, RD=0, Fault=0, Busy=CLEAR_ON_RESET.
  - Array contents are not touched during reset.
- CLEAR state:
  - Each cycle writes 0 to word clr_ptr, then clr_ptr <= clr_ptr+1.
  - On the cycle clr_ptr = 2**ADDR_WIDTH-1: write that word, then go to IDLE. Sweep length is exactly 2**ADDR_WIDTH cycles.
  - Busy=1 and Ready=0 throughout. Req is ignored: no Ack, no write.
- IDLE state:
  - Ready=1. A request is accepted at a rising edge when Req=1 and Ready=1.
  - One access per cycle, fully pipelined: back-to-back requests give back-to-back Acks.
- Address decode:
  - Word index = Address[ADDR_WIDTH+1:2]; lane = Address[1:0].
  - Out of range if any Address[31:ADDR_WIDTH+2] bit is set.
- Funct3 rules:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
  - Stores: 000 SB, 001 SH, 010 SW; all other codes are illegal.
- Misalignment: halfword access with Address[0]=1, or word access with Address[1:0]≠0.
- Fault conditions: illegal code, misaligned, or out of range.
  - Store: no byte is written.
  - Load: RD=0.
  - Either: Ack=1 and Fault=1 next cycle.
- Stores (at the accept edge):
  - SB: WD[7:0] written to lane Address[1:0].
  - SH: WD[15:0] written to lanes {Address[1],0}+1 : {Address[1],0}.
  - SW: all four lanes.
  - Unselected lanes keep their value. Next cycle: Ack=1, RD=0, Fault=0.
- Loads:
  - Word read at the accept edge and registered; RD appears with Ack the next cycle (latency 1).
  - LB/LH sign-extend; LBU/LHU zero-extend; byte/half taken from the addressed lane(s).
- Read after write: a load accepted the cycle after a store to the same word returns the new data. A simultaneous read and write is impossible (one request per cycle).
- Ack, RD and Fault hold their values only for the Ack cycle; with no accept they return to Ack=0, RD=0, Fault=0.
- Reset during CLEAR or mid-access:
  - Sweep restarts from 0.
  - A pending Ack is dropped.
  - A store already committed at an earlier edge stays written.

Decomposition:
- Package dmem_pkg:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: S_CLEAR, S_IDLE.
  - 4-bit byte-enable type.
- Sub-module dmem_lane_align (combinational): from Funct3, Address[1:0], WD and the raw read word, produces byte enables, lane-shifted write data, extended load data and the misalign/illegal flags.
- Top module holds the array, FSM, clear pointer and output registers.

Test Plan (ADDR_WIDTH=4, 16 words):
- Release RST → Busy=1 and Ready=0 for exactly 16 cycles, then Ready=1; a Req during the sweep gets no Ack and causes no write.
- SW 0x8 = 0xDEADBEEF, then LW 0x8 → Ack next cycle, RD=0xDEADBEEF, Fault=0. Then LB 0x9 → RD=0xFFFFFFBE; LBU 0xB → RD=0x000000DE.
- SW 0x0 = 0; SH 0x2 with WD=0x00008001; then LW 0x0 → RD=0x80010000; LH 0x2 → RD=0xFFFF8001; LHU 0x2 → RD=0x00008001.
- Faults with word 0x4 preset to 0x11223344:
  - SW 0x6 → Ack, Fault=1; a later LW 0x4 still returns 0x11223344.
  - LW 0x40 (out of range) → Fault=1, RD=0.
  - Load with Funct3=011 → Fault=1.
- Back-to-back: SB 0xC=0xAA, LBU 0xC, LBU 0xD on three consecutive cycles → three consecutive Acks with RD=0, 0xAA, 0x00.
- Assert RST mid-sweep (cycle 7) and mid-load: Ack drops at once. Release → full 16-cycle sweep, and all words then read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory: RV32I width codes,
// controller states and the byte-enable type.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    typedef logic [3:0] byte_en_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// incoming request, and sign/zero-extended load data for the registered response.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        req_write_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [1:0]  req_lane_i,
    input  logic [31:0] wd_i,
    input  logic [2:0]  rsp_funct3_i,
    input  logic [1:0]  rsp_lane_i,
    input  logic [31:0] rdata_i,
    output byte_en_t    be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request side: replicate store data so the byte enables alone pick the lane.
    always_comb begin
        be_o       = '0;
        wdata_o    = '0;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (req_funct3_i)
            F3_B: begin
                be_o    = byte_en_t'(4'b0001 << req_lane_i);
                wdata_o = {4{wd_i[7:0]}};
            end
            F3_H: begin
                be_o       = req_lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wd_i[15:0]}};
                misalign_o = req_lane_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                wdata_o    = wd_i;
                misalign_o = (req_lane_i != 2'b00);
            end
            F3_BU: illegal_o = req_write_i;
            F3_HU: begin
                illegal_o  = req_write_i;
                misalign_o = req_lane_i[0];
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign ld_byte = rdata_i[{rsp_lane_i, 3'b000} +: 8];
    assign ld_half = rsp_lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        ld_data_o = '0;
        case (rsp_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'h0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'h0, ld_half};
            F3_W:    ld_data_o = rdata_i;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Byte-addressable RV32I data memory: 1-cycle handshaked access with fault
// reporting, and a post-reset sweep that zeroes one word per cycle.
module riscv_dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        Write,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] WD,
    output logic        Ready,
    output logic        Ack,
    output logic [31:0] RD,
    output logic        Fault,
    output logic        Busy
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [0:0] RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                  ready_q, ready_d;
    logic                  ack_q, ack_d;
    logic                  fault_q, fault_d;
    logic                  load_q, load_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;

    logic                  clearing;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  out_of_range;
    logic                  misalign;
    logic                  illegal;
    logic                  req_fault;
    byte_en_t              be;
    logic [31:0]           wdata_lane;
    logic [31:0]           ld_data;

    logic                  mem_we;
    byte_en_t              mem_be;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wd;

    dmem_lane_align u_align (
        .req_write_i  (Write),
        .req_funct3_i (Funct3),
        .req_lane_i   (Address[1:0]),
        .wd_i         (WD),
        .rsp_funct3_i (funct3_q),
        .rsp_lane_i   (lane_q),
        .rdata_i      (rdata_q),
        .be_o         (be),
        .wdata_o      (wdata_lane),
        .ld_data_o    (ld_data),
        .misalign_o   (misalign),
        .illegal_o    (illegal)
    );

    assign clearing     = (state_q == S_CLEAR);
    assign accept       = Req && ready_q;
    assign word_idx     = Address[ADDR_WIDTH+1:2];
    assign out_of_range = |(Address >> (ADDR_WIDTH + 2));
    assign req_fault    = illegal || misalign || out_of_range;

    // The sweep and accepted stores share a single write port.
    assign mem_we  = clearing || (accept && Write && !req_fault);
    assign mem_be  = clearing ? byte_en_t'(4'hF) : be;
    assign mem_idx = clearing ? clr_ptr_q : word_idx;
    assign mem_wd  = clearing ? 32'h0 : wdata_lane;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (clearing) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) begin
                state_d = S_IDLE;
            end
        end
        ready_d  = (state_d == S_IDLE);
        ack_d    = accept;
        fault_d  = accept && req_fault;
        load_d   = accept && !Write;
        funct3_d = Funct3;
        lane_d   = Address[1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= RESET_STATE;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            fault_q   <= 1'b0;
            load_q    <= 1'b0;
            funct3_q  <= '0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            fault_q   <= fault_d;
            load_q    <= load_d;
            funct3_q  <= funct3_d;
            lane_q    <= lane_d;
        end
    end

    // Array and its read register stay reset-free so they map onto block RAM.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) begin
                mem_q[mem_idx][b*8 +: 8] <= mem_wd[b*8 +: 8];
            end
        end
        if (accept && !Write) begin
            rdata_q <= mem_q[word_idx];
        end
    end

    assign Ready = ready_q;
    assign Busy  = clearing;
    assign Ack   = ack_q;
    assign Fault = fault_q;
    assign RD    = (ack_q && load_q && !fault_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl with a 16-word array: clear sweep, widths,
// extension, faults, back-to-back access and reset recovery.
module tb_riscv_dmem_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Req = 1'b0;
    logic        Write = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] Address = 32'h0;
    logic [31:0] WD = 32'h0;
    logic        Ready;
    logic        Ack;
    logic [31:0] RD;
    logic        Fault;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    riscv_dmem_ctrl #(
        .ADDR_WIDTH     (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Req     (Req),
        .Write   (Write),
        .Funct3  (Funct3),
        .Address (Address),
        .WD      (WD),
        .Ready   (Ready),
        .Ack     (Ack),
        .RD      (RD),
        .Fault   (Fault),
        .Busy    (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        Req     = 1'b1;
        Write   = w;
        Funct3  = f3;
        Address = a;
        WD      = d;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] exp_rd, input logic exp_fault);
        chk({tag, " ack"}, {31'h0, Ack}, 32'h1);
        chk({tag, " rd"}, RD, exp_rd);
        chk({tag, " fault"}, {31'h0, Fault}, {31'h0, exp_fault});
        $display("txn %s: Ack=%0b RD=0x%08h Fault=%0b", tag, Ack, RD, Fault);
    endtask

    // One isolated access: drive on a falling edge, check one cycle later.
    task automatic op(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_fault);
        drive(w, f3, a, d);
        @(negedge CLK);
        Req = 1'b0;
        expect_rsp(tag, exp_rd, exp_fault);
    endtask

    // Called on the falling edge where RST is released; Req may be held high.
    task automatic sweep(input string tag);
        int n;
        logic ready_seen;
        logic ack_seen;
        n = 0;
        ready_seen = 1'b0;
        ack_seen = 1'b0;
        while (Busy === 1'b1 && n < 100) begin
            if (Ready !== 1'b0) ready_seen = 1'b1;
            if (Ack !== 1'b0) ack_seen = 1'b1;
            n++;
            @(negedge CLK);
        end
        Req = 1'b0;
        chk({tag, " sweep length"}, n, 32'd16);
        chk({tag, " ready during sweep"}, {31'h0, ready_seen}, 32'h0);
        chk({tag, " ack during sweep"}, {31'h0, ack_seen}, 32'h0);
        chk({tag, " ready after sweep"}, {31'h0, Ready}, 32'h1);
        chk({tag, " ack after sweep"}, {31'h0, Ack}, 32'h0);
        $display("txn %s: sweep cycles=%0d", tag, n);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("reset ready", {31'h0, Ready}, 32'h0);
        chk("reset ack", {31'h0, Ack}, 32'h0);
        chk("reset rd", RD, 32'h0);
        chk("reset fault", {31'h0, Fault}, 32'h0);
        chk("reset busy", {31'h0, Busy}, 32'h1);

        // Sweep with a store pending that must be ignored.
        RST = 1'b1;
        drive(1'b1, 3'b010, 32'h0, 32'hFFFF_FFFF);
        sweep("initial");
        op("lw 0x0 after ignored store", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);

        op("sw 0x8", 1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op("lw 0x8", 1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);
        op("lb 0x9", 1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFF_FFBE, 1'b0);
        op("lbu 0xb", 1'b0, 3'b100, 32'hB, 32'h0, 32'h0000_00DE, 1'b0);

        op("sw 0x0", 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);
        op("sh 0x2", 1'b1, 3'b001, 32'h2, 32'h0000_8001, 32'h0, 1'b0);
        op("lw 0x0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h8001_0000, 1'b0);
        op("lh 0x2", 1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF_8001, 1'b0);
        op("lhu 0x2", 1'b0, 3'b101, 32'h2, 32'h0, 32'h0000_8001, 1'b0);

        op("sw 0x4 preset", 1'b1, 3'b010, 32'h4, 32'h1122_3344, 32'h0, 1'b0);
        op("sw 0x6 misaligned", 1'b1, 3'b010, 32'h6, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op("store f3=011", 1'b1, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1);
        op("sb 0x40 out of range", 1'b1, 3'b000, 32'h40, 32'h55, 32'h0, 1'b1);
        op("lw 0x4 unchanged", 1'b0, 3'b010, 32'h4, 32'h0, 32'h1122_3344, 1'b0);
        op("lw 0x40 out of range", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1);
        op("load f3=011", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1);
        op("lh 0x5 misaligned", 1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 1'b1);

        // Three consecutive requests give three consecutive Acks.
        drive(1'b1, 3'b000, 32'hC, 32'h0000_00AA);
        @(negedge CLK);
        expect_rsp("b2b sb 0xc", 32'h0, 1'b0);
        drive(1'b0, 3'b100, 32'hC, 32'h0);
        @(negedge CLK);
        expect_rsp("b2b lbu 0xc", 32'h0000_00AA, 1'b0);
        drive(1'b0, 3'b100, 32'hD, 32'h0);
        @(negedge CLK);
        Req = 1'b0;
        expect_rsp("b2b lbu 0xd", 32'h0, 1'b0);
        @(negedge CLK);
        chk("ack idle after b2b", {31'h0, Ack}, 32'h0);
        chk("rd idle after b2b", RD, 32'h0);

        // Reset while a load response is on the outputs.
        drive(1'b0, 3'b010, 32'h8, 32'h0);
        @(posedge CLK);
        #1;
        Req = 1'b0;
        chk("mid-load ack before reset", {31'h0, Ack}, 32'h1);
        RST = 1'b0;
        #1;
        chk("mid-load ack dropped", {31'h0, Ack}, 32'h0);
        chk("mid-load rd dropped", RD, 32'h0);
        chk("mid-load busy", {31'h0, Busy}, 32'h1);
        $display("txn reset mid-load: Ack=%0b Busy=%0b", Ack, Busy);
        @(negedge CLK);
        RST = 1'b1;

        // Interrupt the sweep at cycle 7, then let a full sweep run.
        repeat (7) @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("mid-sweep busy", {31'h0, Busy}, 32'h1);
        chk("mid-sweep ready", {31'h0, Ready}, 32'h0);
        chk("mid-sweep ack", {31'h0, Ack}, 32'h0);
        $display("txn reset mid-sweep: Busy=%0b Ready=%0b", Busy, Ready);
        @(negedge CLK);
        RST = 1'b1;
        sweep("restart");

        for (int i = 0; i < 16; i++) begin
            op($sformatf("lw 0x%02h after clear", i * 4), 1'b0, 3'b010,
               32'(i * 4), 32'h0, 32'h0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
